// File: rtl/hazard_forward_ctrl_if.sv
// Bundle between the pipeline and the hazard/forwarding controller.
// The master side drives the pipeline-stage fields; the slave side returns the selects and stalls.
interface hazard_forward_ctrl_if #(
  parameter int NSRC = 2,
  parameter int AW   = 5
);
  logic [NSRC*AW-1:0] id_rs;
  logic [NSRC*AW-1:0] ex_rs;
  logic [AW-1:0]      ex_rd;
  logic               ex_memread;
  logic               mc_start;
  logic               mc_done;
  logic [AW-1:0]      mem_rd;
  logic               mem_regwrite;
  logic               mem_memread;
  logic [AW-1:0]      wb_rd;
  logic               wb_regwrite;
  logic [NSRC*2-1:0]  fwd_sel;
  logic               stall_if;
  logic               stall_id;
  logic               stall_ex;
  logic               bubble_ex;
  logic               bubble_mem;

  modport master (
    output id_rs, ex_rs, ex_rd, ex_memread, mc_start, mc_done,
           mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite,
    input  fwd_sel, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem
  );

  modport slave (
    input  id_rs, ex_rs, ex_rd, ex_memread, mc_start, mc_done,
           mem_rd, mem_regwrite, mem_memread, wb_rd, wb_regwrite,
    output fwd_sel, stall_if, stall_id, stall_ex, bubble_ex, bubble_mem
  );
endinterface

// File: rtl/hazard_forward_ctrl.sv
// Operand forwarding and load-use / multi-cycle interlock for the 5-stage core.
// Optional macro HAZARD_STATS_EN adds saturating stall-cycle counters as extra ports.
module hazard_forward_ctrl #(
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  hazard_forward_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]            ld_stall_cnt,
  output logic [31:0]            mc_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, LDSTALL, MCBUSY} state_e;

  localparam logic [3:0] LD_RELOAD = 4'(LOAD_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        ld_cnt_q, ld_cnt_d;
  logic              id_match;
  logic              ld_hit;
  logic [NSRC*2-1:0] fwd_s;
  logic              stall_if_s, stall_id_s, stall_ex_s, bubble_ex_s, bubble_mem_s;

  always_comb begin
    id_match = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.id_rs[i*AW +: AW] == bus.ex_rd) id_match = 1'b1;
    end
  end

  assign ld_hit = (state_q == IDLE) && bus.ex_memread && (bus.ex_rd != '0) && id_match;

  // MEM is the younger producer so it takes priority; a load in MEM has no data yet.
  always_comb begin
    fwd_s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.ex_rs[i*AW +: AW] != '0) begin
        if (bus.mem_regwrite && !bus.mem_memread && (bus.mem_rd == bus.ex_rs[i*AW +: AW]))
          fwd_s[2*i +: 2] = 2'b10;
        else if (bus.wb_regwrite && (bus.wb_rd == bus.ex_rs[i*AW +: AW]))
          fwd_s[2*i +: 2] = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ld_cnt_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.mc_start) begin
          state_d = MCBUSY;
        end else if (ld_hit && (LOAD_LAT > 1)) begin
          state_d  = LDSTALL;
          ld_cnt_d = LD_RELOAD;
        end
      end
      LDSTALL: begin
        ld_cnt_d = ld_cnt_q - 4'd1;
        if (ld_cnt_q <= 4'd1) state_d = IDLE;
      end
      MCBUSY: begin
        if (bus.mc_done) state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        ld_cnt_d = 4'd0;
      end
    endcase
  end

  // Outputs are forced low for as long as reset is held, independent of the clock.
  always_comb begin
    stall_if_s   = 1'b0;
    stall_id_s   = 1'b0;
    stall_ex_s   = 1'b0;
    bubble_ex_s  = 1'b0;
    bubble_mem_s = 1'b0;
    if (reset_n) begin
      case (state_q)
        IDLE: begin
          if (!bus.mc_start && ld_hit) begin
            stall_if_s  = 1'b1;
            stall_id_s  = 1'b1;
            bubble_ex_s = 1'b1;
          end
        end
        LDSTALL: begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          bubble_ex_s = 1'b1;
        end
        MCBUSY: begin
          if (!bus.mc_done) begin
            stall_if_s   = 1'b1;
            stall_id_s   = 1'b1;
            stall_ex_s   = 1'b1;
            bubble_mem_s = 1'b1;
          end
        end
        default: begin
          stall_if_s = 1'b0;
        end
      endcase
    end
  end

  assign bus.fwd_sel    = reset_n ? fwd_s : '0;
  assign bus.stall_if   = stall_if_s;
  assign bus.stall_id   = stall_id_s;
  assign bus.stall_ex   = stall_ex_s;
  assign bus.bubble_ex  = bubble_ex_s;
  assign bus.bubble_mem = bubble_mem_s;

`ifdef HAZARD_STATS_EN
  logic [31:0] ld_stat_q, mc_stat_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_stat_q <= 32'd0;
      mc_stat_q <= 32'd0;
    end else begin
      if (bubble_ex_s) ld_stat_q <= sat_inc(ld_stat_q);
      if (stall_ex_s)  mc_stat_q <= sat_inc(mc_stat_q);
    end
  end

  assign ld_stall_cnt = ld_stat_q;
  assign mc_stall_cnt = mc_stat_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: two instances (LOAD_LAT 1 and 3) share one stimulus stream,
// each checked against a cycle model through per-instance expectation queues.
module tb_hazard_forward_ctrl;

  typedef logic [8:0] exp_t;  // {fwd_sel[3:0], stall_if, stall_id, stall_ex, bubble_ex, bubble_mem}

  logic       clk;
  logic       reset_n;
  logic [9:0] id_rs, ex_rs;
  logic [4:0] ex_rd, mem_rd, wb_rd;
  logic       ex_memread, mc_start, mc_done, mem_regwrite, mem_memread, wb_regwrite;

  int checks;
  int passed;

  exp_t sb1[$];
  exp_t sb3[$];

  int          ld_rem [2];
  int          ld_rem_n [2];
  bit          busy [2];
  bit          busy_n [2];
  int unsigned exp_ld [2];
  int unsigned exp_mc [2];
  bit          pend_ld [2];
  bit          pend_mc [2];

  hazard_forward_ctrl_if #(.NSRC(2), .AW(5)) if1 ();
  hazard_forward_ctrl_if #(.NSRC(2), .AW(5)) if3 ();

  assign if1.id_rs = id_rs;         assign if3.id_rs = id_rs;
  assign if1.ex_rs = ex_rs;         assign if3.ex_rs = ex_rs;
  assign if1.ex_rd = ex_rd;         assign if3.ex_rd = ex_rd;
  assign if1.ex_memread = ex_memread;     assign if3.ex_memread = ex_memread;
  assign if1.mc_start = mc_start;   assign if3.mc_start = mc_start;
  assign if1.mc_done = mc_done;     assign if3.mc_done = mc_done;
  assign if1.mem_rd = mem_rd;       assign if3.mem_rd = mem_rd;
  assign if1.mem_regwrite = mem_regwrite; assign if3.mem_regwrite = mem_regwrite;
  assign if1.mem_memread = mem_memread;   assign if3.mem_memread = mem_memread;
  assign if1.wb_rd = wb_rd;         assign if3.wb_rd = wb_rd;
  assign if1.wb_regwrite = wb_regwrite;   assign if3.wb_regwrite = wb_regwrite;

`ifdef HAZARD_STATS_EN
  logic [31:0] ld_cnt1, mc_cnt1, ld_cnt3, mc_cnt3;
`endif

  hazard_forward_ctrl #(.NSRC(2), .AW(5), .LOAD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(if1)
`ifdef HAZARD_STATS_EN
    , .ld_stall_cnt(ld_cnt1), .mc_stall_cnt(mc_cnt1)
`endif
  );

  hazard_forward_ctrl #(.NSRC(2), .AW(5), .LOAD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3)
`ifdef HAZARD_STATS_EN
    , .ld_stall_cnt(ld_cnt3), .mc_stall_cnt(mc_cnt3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog");
  end

  function automatic exp_t obs1();
    return {if1.fwd_sel, if1.stall_if, if1.stall_id, if1.stall_ex, if1.bubble_ex, if1.bubble_mem};
  endfunction

  function automatic exp_t obs3();
    return {if3.fwd_sel, if3.stall_if, if3.stall_id, if3.stall_ex, if3.bubble_ex, if3.bubble_mem};
  endfunction

  task automatic idle_in();
    id_rs = '0; ex_rs = '0; ex_rd = '0; ex_memread = 0; mc_start = 0; mc_done = 0;
    mem_rd = '0; mem_regwrite = 0; mem_memread = 0; wb_rd = '0; wb_regwrite = 0;
  endtask

  // Reference behaviour: a busy flag and a count of load stalls still owed.
  task automatic model_step(input int k, output exp_t e);
    logic [3:0] f;
    logic si, sd, se, be, bm;
    bit   hit;
    int   lat;
    lat = (k == 0) ? 1 : 3;
    f = '0; si = 0; sd = 0; se = 0; be = 0; bm = 0;
    ld_rem_n[k] = ld_rem[k];
    busy_n[k]   = busy[k];
    pend_ld[k]  = 0;
    pend_mc[k]  = 0;
    if (!reset_n) begin
      e = '0;
      ld_rem_n[k] = 0;
      busy_n[k]   = 0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      logic [4:0] r;
      r = ex_rs[i*5 +: 5];
      if (r != 0 && mem_regwrite && !mem_memread && mem_rd == r) f[i*2 +: 2] = 2'b10;
      else if (r != 0 && wb_regwrite && wb_rd == r)               f[i*2 +: 2] = 2'b01;
    end
    hit = ex_memread && (ex_rd != 0) && ((id_rs[4:0] == ex_rd) || (id_rs[9:5] == ex_rd));
    if (busy[k]) begin
      if (mc_done) busy_n[k] = 0;
      else begin si = 1; sd = 1; se = 1; bm = 1; end
    end else if (ld_rem[k] > 0) begin
      si = 1; sd = 1; be = 1;
      ld_rem_n[k] = ld_rem[k] - 1;
    end else if (mc_start) begin
      if (hit) $display("note: illegal stimulus, mc_start with load-use hit");
      busy_n[k] = 1;
    end else if (hit) begin
      si = 1; sd = 1; be = 1;
      ld_rem_n[k] = lat - 1;
    end
    pend_ld[k] = be;
    pend_mc[k] = se;
    e = {f, si, sd, se, be, bm};
  endtask

  task automatic push_expect();
    exp_t e;
    model_step(0, e); sb1.push_back(e);
    model_step(1, e); sb3.push_back(e);
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      ld_rem[k] = ld_rem_n[k];
      busy[k]   = busy_n[k];
      if (!reset_n) begin
        exp_ld[k] = 0;
        exp_mc[k] = 0;
      end else begin
        exp_ld[k] += pend_ld[k];
        exp_mc[k] += pend_mc[k];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    exp_t e1, e3;
    for (int c = 0; c < 2; c++) begin
      idle_in();
      ex_rs = {5'd3, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1; wb_rd = 5'd3; wb_regwrite = 1;
      ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd7};
      push_expect();
      @(negedge clk);
      e1 = sb1.pop_front(); e3 = sb3.pop_front();
      checks++; if (obs1() !== e1) $display("FAIL reset c%0d lat1 got %b want %b", c, obs1(), e1); else passed++;
      checks++; if (obs3() !== e3) $display("FAIL reset c%0d lat3 got %b want %b", c, obs3(), e3); else passed++;
      advance();
    end
    reset_n = 1;
  endtask

  task automatic test_forwarding();
    exp_t e1, e3;
    for (int c = 0; c < 14; c++) begin
      idle_in();
      case (c)
        0: begin ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1; wb_rd = 5'd5; wb_regwrite = 1; end
        1: begin ex_rs = {5'd0, 5'd5}; mem_rd = 5'd5; wb_rd = 5'd5; wb_regwrite = 1; end
        2: begin ex_rs = 10'd0; mem_rd = 5'd0; mem_regwrite = 1; wb_rd = 5'd0; wb_regwrite = 1; end
        3: begin ex_rs = {5'd5, 5'd5}; mem_rd = 5'd5; mem_regwrite = 1; mem_memread = 1; wb_rd = 5'd5; wb_regwrite = 1; end
        4: begin ex_rs = {5'd9, 5'd4}; mem_rd = 5'd9; mem_regwrite = 1; wb_rd = 5'd4; wb_regwrite = 1; end
        5: begin ex_rs = {5'd31, 5'd6}; mem_rd = 5'd6; mem_regwrite = 1; wb_rd = 5'd31; wb_regwrite = 0; end
        default: begin
          ex_rs[4:0] = 5'($urandom_range(0, 3)); ex_rs[9:5] = 5'($urandom_range(0, 3));
          mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
          mem_regwrite = 1'($urandom); mem_memread = 1'($urandom); wb_regwrite = 1'($urandom);
        end
      endcase
      push_expect();
      @(negedge clk);
      e1 = sb1.pop_front(); e3 = sb3.pop_front();
      checks++; if (obs1() !== e1) $display("FAIL fwd c%0d lat1 got %b want %b", c, obs1(), e1); else passed++;
      checks++; if (obs3() !== e3) $display("FAIL fwd c%0d lat3 got %b want %b", c, obs3(), e3); else passed++;
      advance();
    end
  endtask

  task automatic test_load_use();
    exp_t e1, e3;
    for (int c = 0; c < 7; c++) begin
      idle_in();
      case (c)
        0: begin ex_memread = 1; ex_rd = 5'd7; id_rs = {5'd7, 5'd2}; end
        1: mc_start = 1;
        3: mc_done = 1;
        5: begin ex_memread = 1; ex_rd = 5'd0; id_rs = 10'd0; end
        default: ;
      endcase
      push_expect();
      @(negedge clk);
      e1 = sb1.pop_front(); e3 = sb3.pop_front();
      checks++; if (obs1() !== e1) $display("FAIL load_use c%0d lat1 got %b want %b", c, obs1(), e1); else passed++;
      checks++; if (obs3() !== e3) $display("FAIL load_use c%0d lat3 got %b want %b", c, obs3(), e3); else passed++;
      advance();
    end
  endtask

  task automatic test_multicycle();
    exp_t e1, e3;
    for (int c = 0; c < 10; c++) begin
      idle_in();
      ex_rs = {5'd1, 5'd2}; mem_rd = 5'd2; mem_regwrite = 1;
      case (c)
        0: mc_start = 1;
        2: begin ex_memread = 1; ex_rd = 5'd8; id_rs = {5'd0, 5'd8}; end
        5: begin mc_done = 1; ex_memread = 1; ex_rd = 5'd8; id_rs = {5'd0, 5'd8}; end
        6: begin ex_memread = 1; ex_rd = 5'd8; id_rs = {5'd0, 5'd8}; end
        default: ;
      endcase
      push_expect();
      @(negedge clk);
      e1 = sb1.pop_front(); e3 = sb3.pop_front();
      checks++; if (obs1() !== e1) $display("FAIL multicycle c%0d lat1 got %b want %b", c, obs1(), e1); else passed++;
      checks++; if (obs3() !== e3) $display("FAIL multicycle c%0d lat3 got %b want %b", c, obs3(), e3); else passed++;
      advance();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e3;
    for (int c = 0; c < 7; c++) begin
      idle_in();
      case (c)
        0: begin ex_memread = 1; ex_rd = 5'd3; id_rs = {5'd0, 5'd3}; end
        1: begin ex_memread = 1; ex_rd = 5'd4; id_rs = {5'd4, 5'd0}; end
        4: mc_start = 1;
        5: mc_done = 1;
        default: ;
      endcase
      push_expect();
      @(negedge clk);
      e1 = sb1.pop_front(); e3 = sb3.pop_front();
      checks++; if (obs1() !== e1) $display("FAIL back_to_back c%0d lat1 got %b want %b", c, obs1(), e1); else passed++;
      checks++; if (obs3() !== e3) $display("FAIL back_to_back c%0d lat3 got %b want %b", c, obs3(), e3); else passed++;
      advance();
    end
  endtask

  task automatic test_reset_mid();
    exp_t e1, e3;
    for (int c = 0; c < 9; c++) begin
      idle_in();
      ex_rs = {5'd0, 5'd5}; wb_rd = 5'd5; wb_regwrite = 1;
      case (c)
        0: mc_start = 1;
        2: reset_n = 0;
        4: reset_n = 1;
        5: begin ex_memread = 1; ex_rd = 5'd6; id_rs = {5'd6, 5'd0}; end
        default: ;
      endcase
      push_expect();
      @(negedge clk);
      e1 = sb1.pop_front(); e3 = sb3.pop_front();
      checks++; if (obs1() !== e1) $display("FAIL reset_mid c%0d lat1 got %b want %b", c, obs1(), e1); else passed++;
      checks++; if (obs3() !== e3) $display("FAIL reset_mid c%0d lat3 got %b want %b", c, obs3(), e3); else passed++;
      advance();
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    checks++; if (ld_cnt1 !== exp_ld[0]) $display("FAIL stats ld lat1 got %0d want %0d", ld_cnt1, exp_ld[0]); else passed++;
    checks++; if (mc_cnt1 !== exp_mc[0]) $display("FAIL stats mc lat1 got %0d want %0d", mc_cnt1, exp_mc[0]); else passed++;
    checks++; if (ld_cnt3 !== exp_ld[1]) $display("FAIL stats ld lat3 got %0d want %0d", ld_cnt3, exp_ld[1]); else passed++;
    checks++; if (mc_cnt3 !== exp_mc[1]) $display("FAIL stats mc lat3 got %0d want %0d", mc_cnt3, exp_mc[1]); else passed++;
    advance();
  endtask
`endif

  initial begin
    checks = 0;
    passed = 0;
    for (int k = 0; k < 2; k++) begin
      ld_rem[k] = 0; ld_rem_n[k] = 0; busy[k] = 0; busy_n[k] = 0;
      exp_ld[k] = 0; exp_mc[k] = 0; pend_ld[k] = 0; pend_mc[k] = 0;
    end
    reset_n = 0;
    idle_in();
    @(posedge clk);
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_multicycle();
    test_back_to_back();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_reset_mid();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
